// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline-register taps in, PC/IF/ID/mux controls out.
// The pipeline side takes the master modport; the hazard controller takes slave.
interface hazard_ctrl_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
);
  logic [REG_ADDR_W-1:0] id_rs_i;
  logic [REG_ADDR_W-1:0] id_rt_i;
  logic                  id_uses_rt_i;
  logic                  ex_memread_i;
  logic [REG_ADDR_W-1:0] ex_rd_i;
  logic                  branch_taken_i;

  logic                  pc_write_o;
  logic                  ifid_write_o;
  logic                  ifid_flush_o;
  logic                  idex_bubble_sel_o;
  logic                  pc_src_sel_o;
  logic [CNT_W-1:0]      stall_cnt_o;
  logic [CNT_W-1:0]      flush_cnt_o;

  modport master (
    output id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i, branch_taken_i,
    input  pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_sel_o, pc_src_sel_o,
           stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_rs_i, id_rt_i, id_uses_rt_i, ex_memread_i, ex_rd_i, branch_taken_i,
    output pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_sel_o, pc_src_sel_o,
           stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-branch front-end flush and
// saturating stall/flush event counters for the 5-stage pipeline.
module hazard_ctrl #(
  parameter int REG_ADDR_W   = 5,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic         clk_i,
  input  logic         rst_i,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG     = '0;
  localparam logic [3:0]            FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
  localparam bit                    MULTI_FLUSH  = (FLUSH_CYCLES > 1);

  state_t           state;
  logic [3:0]       flush_left;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  logic rd_hits;
  logic lu;
  logic br;

  logic pc_write;
  logic ifid_write;
  logic ifid_flush;
  logic idex_bubble_sel;
  logic pc_src_sel;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  // lu only counts in IDLE: STALL and FLUSH both mask it, which also prevents
  // a second stall on the same load that is still sitting in EX.
  assign rd_hits = (bus.ex_rd_i == bus.id_rs_i) |
                   (bus.id_uses_rt_i & (bus.ex_rd_i == bus.id_rt_i));
  assign lu      = bus.ex_memread_i & (bus.ex_rd_i != ZERO_REG) & rd_hits &
                   (state == IDLE);
  assign br      = bus.branch_taken_i;

  // NOTE: every output gets a default before the branches so no path leaves
  // it unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    pc_write        = 1'b1;
    ifid_write      = 1'b1;
    ifid_flush      = 1'b0;
    idex_bubble_sel = 1'b0;
    pc_src_sel      = 1'b0;
    if (!rst_i) begin
      if (br) begin
        pc_src_sel      = 1'b1;
        ifid_flush      = 1'b1;
        idex_bubble_sel = 1'b1;
      end else if (state == FLUSH) begin
        ifid_flush      = 1'b1;
        idex_bubble_sel = 1'b1;
      end else if (lu) begin
        pc_write        = 1'b0;
        ifid_write      = 1'b0;
        idex_bubble_sel = 1'b1;
      end
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      flush_left <= '0;
      stall_cnt  <= '0;
      flush_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE, STALL: begin
          if (br) begin
            flush_cnt <= sat_inc(flush_cnt);
            if (MULTI_FLUSH) begin
              state      <= FLUSH;
              flush_left <= FLUSH_RELOAD;
            end else begin
              state <= IDLE;
            end
          end else if (lu) begin
            stall_cnt <= sat_inc(stall_cnt);
            state     <= STALL;
          end else begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          // A fresh branch restarts the countdown; the current cycle already
          // counts as the first flush cycle of the new redirect.
          if (br) begin
            flush_cnt  <= sat_inc(flush_cnt);
            flush_left <= FLUSH_RELOAD;
          end else if (flush_left <= 4'd1) begin
            state      <= IDLE;
            flush_left <= '0;
          end else begin
            flush_left <= flush_left - 4'd1;
          end
        end
        default: begin
          state      <= IDLE;
          flush_left <= '0;
        end
      endcase
    end
  end

  assign bus.pc_write_o        = pc_write;
  assign bus.ifid_write_o      = ifid_write;
  assign bus.ifid_flush_o      = ifid_flush;
  assign bus.idex_bubble_sel_o = idex_bubble_sel;
  assign bus.pc_src_sel_o      = pc_src_sel;
  assign bus.stall_cnt_o       = stall_cnt;
  assign bus.flush_cnt_o       = flush_cnt;

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage pipeline CPU. It drives the select inputs of the 2:1 muxes in IF/ID, the PC-source mux and the ID/EX control-bubble mux.
- Detects load-use hazards and taken-branch redirects. It sequences a one-cycle stall or a multi-cycle front-end flush, and keeps saturating event counters for performance debug.
- Sits between the ID/EX/MEM pipeline registers (inputs) and the PC, IF/ID and mux-select nets (outputs).

Parameters:
- REG_ADDR_W, 5, register-index width.
- FLUSH_CYCLES, 1, total cycles ifid_flush_o is held after a taken branch (legal range 1..15).
- CNT_W, 16, width of the stall and flush event counters.

Ports:
- clk_i  input  1  clock, rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- id_rs_i  input  REG_ADDR_W  rs index of the instruction in ID.
- id_rt_i  input  REG_ADDR_W  rt index of the instruction in ID.
- id_uses_rt_i  input  1  the ID instruction reads rt.
- ex_memread_i  input  1  the EX instruction is a load.
- ex_rd_i  input  REG_ADDR_W  destination index of the EX instruction.
- branch_taken_i  input  1  branch resolved taken; single-cycle pulse from EX/MEM.
- pc_write_o  output  1  PC register write enable.
- ifid_write_o  output  1  IF/ID register write enable.
- ifid_flush_o  output  1  IF/ID flush; select of the IF/ID NOP mux.
- idex_bubble_sel_o  output  1  select of the ID/EX control mux (1 = zero controls).
- pc_src_sel_o  output  1  select of the PC-source mux (1 = branch target).
- stall_cnt_o  output  CNT_W  saturating count of load-use stalls.
- flush_cnt_o  output  CNT_W  saturating count of taken-branch flushes.

Behaviour:
- Reset (rst_i=1, takes effect asynchronously):
  - state=IDLE, flush_left=0, both counters 0.
  - Outputs forced to pc_write_o=1, ifid_write_o=1, all flush/select outputs 0.
- Load-use detect (combinational):
  - lu = ex_memread_i & (ex_rd_i!=0) & ((ex_rd_i==id_rs_i) | (id_uses_rt_i & ex_rd_i==id_rt_i)).
- Branch detect: br = branch_taken_i.
- States: IDLE, STALL, FLUSH. All hazard outputs are combinational from state and the current inputs, so they act in the same cycle.
- IDLE, br=1 (br has priority over lu in the same cycle):
  - Outputs: pc_src_sel_o=1, ifid_flush_o=1, idex_bubble_sel_o=1, pc_write_o=1, ifid_write_o=1.
  - flush_cnt increments.
  - If FLUSH_CYCLES>1: go to FLUSH with flush_left=FLUSH_CYCLES-1. Otherwise stay in IDLE.
- IDLE, lu=1, br=0:
  - Outputs: pc_write_o=0, ifid_write_o=0, idex_bubble_sel_o=1.
  - stall_cnt increments; go to STALL.
- IDLE, neither: all outputs at their inactive values (the same values as in reset).
- STALL (exactly 1 cycle):
  - lu is masked, so no back-to-back stall for the same load.
  - Outputs inactive unless br=1. br=1 is handled exactly as in IDLE, including the transition.
  - Otherwise return to IDLE.
- FLUSH:
  - ifid_flush_o=1, idex_bubble_sel_o=1, pc_src_sel_o=0; lu is masked.
  - flush_left decrements; go to IDLE when it reaches 1 (i.e. after its last cycle).
  - A new br in FLUSH: pc_src_sel_o=1, flush_left reloads to FLUSH_CYCLES-1, flush_cnt increments.
- Counters: increment by 1 per event and saturate at all-ones (no wrap).
- ex_rd_i==0 never causes a stall; $zero is excluded.
- Reset asserted mid-STALL or mid-FLUSH: immediate return to IDLE with reset output values. No residual flush is delivered after reset deasserts.

Test Plan:
- Reset then idle:
  - Stimulus: rst_i=1 for 2 cycles, then release with all inputs 0.
  - Required: pc_write_o=1, ifid_write_o=1, all selects 0, both counters 0.
- Load-use on rs:
  - Stimulus: ex_memread_i=1, ex_rd_i=8, id_rs_i=8.
  - Required, same cycle: pc_write_o=0, ifid_write_o=0, idex_bubble_sel_o=1.
  - Required, next cycle (inputs held): outputs inactive (STALL masks lu); stall_cnt_o=1.
- No stall:
  - Stimulus: rt match with id_uses_rt_i=0, or ex_rd_i=0 with id_rs_i=0.
  - Required: no stall; stall_cnt_o stays 0.
- Branch and load-use same cycle (FLUSH_CYCLES=1):
  - Stimulus: branch_taken_i=1 with lu=1.
  - Required: pc_src_sel_o=1, ifid_flush_o=1, pc_write_o=1; flush_cnt_o=1, stall_cnt_o=0.
- Multi-cycle flush (FLUSH_CYCLES=3):
  - Stimulus: one branch pulse.
  - Required: ifid_flush_o high for exactly 3 cycles; pc_src_sel_o high only in the first.
  - Variant: a second pulse in cycle 2 extends the flush so the last flush cycle is cycle 4; flush_cnt_o=2.
- Reset mid-flush and saturation:
  - Stimulus: assert rst_i during FLUSH cycle 2.
  - Required: ifid_flush_o=0 immediately and after release.
  - Saturation (CNT_W=2): 5 load-use events -> stall_cnt_o=3.
